// File: rtl/branch_resolve_bht_if.sv
// Pipeline-facing bundle of the branch resolution unit: IF lookup, EX operands,
// registered branch outcome and statistics.
interface branch_resolve_bht_if #(
   parameter int XLEN   = 32,
   parameter int STAT_W = 16
);
   logic [XLEN-1:0]   if_pc;
   logic              if_pred_taken;
   logic              ex_valid;
   logic              ex_flush;
   logic [6:0]        ex_opcode;
   logic [2:0]        ex_funct3;
   logic [XLEN-1:0]   ex_pc;
   logic [XLEN-1:0]   ex_rs1;
   logic [XLEN-1:0]   ex_rs2;
   logic [12:0]       ex_imm;
   logic              ex_pred_taken;
   logic              br_valid;
   logic              br_taken;
   logic [XLEN-1:0]   br_target;
   logic              br_mispredict;
   logic [XLEN-1:0]   redirect_pc;
   logic              br_illegal;
   logic [STAT_W-1:0] stat_branches;
   logic [STAT_W-1:0] stat_mispredicts;

   // pipeline side
   modport master (
      output if_pc, ex_valid, ex_flush, ex_opcode, ex_funct3, ex_pc,
             ex_rs1, ex_rs2, ex_imm, ex_pred_taken,
      input  if_pred_taken, br_valid, br_taken, br_target, br_mispredict,
             redirect_pc, br_illegal, stat_branches, stat_mispredicts
   );

   // resolution unit side
   modport slave (
      input  if_pc, ex_valid, ex_flush, ex_opcode, ex_funct3, ex_pc,
             ex_rs1, ex_rs2, ex_imm, ex_pred_taken,
      output if_pred_taken, br_valid, br_taken, br_target, br_mispredict,
             redirect_pc, br_illegal, stat_branches, stat_mispredicts
   );
endinterface

// File: rtl/branch_resolve_bht.sv
// RV32I conditional branch resolver with a direct-mapped 2-bit counter BHT
// and saturating branch/mispredict statistics. One-cycle registered outcome.
module branch_resolve_bht #(
   parameter int         XLEN        = 32,
   parameter int         BHT_ENTRIES = 64,
   parameter logic [1:0] CNT_INIT    = 2'b01,
   parameter int         STAT_W      = 16
) (
   input logic                 clk,
   input logic                 reset,
   branch_resolve_bht_if.slave bus
);
   localparam int IDX = $clog2(BHT_ENTRIES);

   logic [1:0]        bht [BHT_ENTRIES];
   logic [IDX-1:0]    rd_idx, wr_idx;
   logic              res, legal, cond, upd;
   logic [XLEN-1:0]   tgt, seq;
   logic              r_valid, r_taken, r_mis, r_ill;
   logic [XLEN-1:0]   r_target, r_redirect;
   logic [STAT_W-1:0] r_sb, r_sm;
   logic              unused_pc_bits;

   // Only the word-aligned index bits of the PCs address the table.
   assign rd_idx         = bus.if_pc[IDX+1:2];
   assign wr_idx         = bus.ex_pc[IDX+1:2];
   assign unused_pc_bits = ^{bus.if_pc[1:0], bus.if_pc[XLEN-1:IDX+2]};

   // Prediction reads the stored counter; an update on the same edge is not bypassed.
   assign bus.if_pred_taken = bht[rd_idx][1];

   // Decode the branch, evaluate its condition and form both candidate next PCs.
   always_comb begin
      res   = bus.ex_valid & ~bus.ex_flush & (bus.ex_opcode == 7'b1100011);
      legal = 1'b1;
      cond  = 1'b0;
      case (bus.ex_funct3)
         3'b000:  cond = (bus.ex_rs1 == bus.ex_rs2);
         3'b001:  cond = (bus.ex_rs1 != bus.ex_rs2);
         3'b100:  cond = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
         3'b101:  cond = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
         3'b110:  cond = (bus.ex_rs1 <  bus.ex_rs2);
         3'b111:  cond = (bus.ex_rs1 >= bus.ex_rs2);
         default: legal = 1'b0;
      endcase
      upd = res & legal;
      tgt = bus.ex_pc + {{(XLEN-13){bus.ex_imm[12]}}, bus.ex_imm};
      seq = bus.ex_pc + XLEN'(4);
   end

   // Outcome register; target/redirect keep their last value when nothing resolves.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid    <= 1'b0;
         r_taken    <= 1'b0;
         r_mis      <= 1'b0;
         r_ill      <= 1'b0;
         r_target   <= '0;
         r_redirect <= '0;
      end else begin
         r_valid <= upd;
         r_taken <= upd & cond;
         r_mis   <= upd & (cond ^ bus.ex_pred_taken);
         r_ill   <= res & ~legal;
         if (upd) begin
            r_target   <= tgt;
            r_redirect <= cond ? tgt : seq;
         end
      end
   end

   // Saturating 2-bit counter training on each legal resolved branch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CNT_INIT;
      end else if (upd) begin
         if (cond && bht[wr_idx] != 2'b11)
            bht[wr_idx] <= bht[wr_idx] + 2'b01;
         else if (!cond && bht[wr_idx] != 2'b00)
            bht[wr_idx] <= bht[wr_idx] - 2'b01;
      end
   end

   // Statistics counters stick at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sb <= '0;
         r_sm <= '0;
      end else if (upd) begin
         if (r_sb != '1) r_sb <= r_sb + STAT_W'(1);
         if ((cond ^ bus.ex_pred_taken) && r_sm != '1) r_sm <= r_sm + STAT_W'(1);
      end
   end

   assign bus.br_valid         = r_valid;
   assign bus.br_taken         = r_taken;
   assign bus.br_mispredict    = r_mis;
   assign bus.br_illegal       = r_ill;
   assign bus.br_target        = r_target;
   assign bus.redirect_pc      = r_redirect;
   assign bus.stat_branches    = r_sb;
   assign bus.stat_mispredicts = r_sm;
endmodule

// File: tb/tb_branch_resolve_bht.sv
// Scoreboard bench: every issued EX cycle pushes its expected registered outcome,
// a monitor pops and compares one cycle later; tasks add prediction/stat checks.
module tb_branch_resolve_bht;
   localparam int SW = 4;

   typedef struct packed {
      logic          valid, taken, mis, ill;
      logic [31:0]   target, redirect;
      logic [SW-1:0] sb, sm;
   } res_t;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   res_t scb[$];

   logic [1:0]    mbht [64];
   logic [31:0]   m_tgt, m_red;
   logic [SW-1:0] m_sb, m_sm;

   branch_resolve_bht_if #(.XLEN(32), .STAT_W(SW)) ifc ();
   branch_resolve_bht #(.XLEN(32), .BHT_ENTRIES(64), .CNT_INIT(2'b01), .STAT_W(SW))
      dut (.clk(clk), .reset(reset), .bus(ifc));

   always #5 clk = ~clk;

   // Compare the registered outcome against the oldest expectation.
   always @(posedge clk) begin
      res_t e, got;
      #1;
      if (scb.size() > 0) begin
         e   = scb.pop_front();
         got = {ifc.br_valid, ifc.br_taken, ifc.br_mispredict, ifc.br_illegal,
                ifc.br_target, ifc.redirect_pc, ifc.stat_branches, ifc.stat_mispredicts};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL scoreboard got v=%0b t=%0b m=%0b i=%0b tgt=%h red=%h sb=%0d sm=%0d want v=%0b t=%0b m=%0b i=%0b tgt=%h red=%h sb=%0d sm=%0d",
                     got.valid, got.taken, got.mis, got.ill, got.target, got.redirect, got.sb, got.sm,
                     e.valid, e.taken, e.mis, e.ill, e.target, e.redirect, e.sb, e.sm);
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 64; i++) mbht[i] = 2'b01;
      m_tgt = '0; m_red = '0; m_sb = '0; m_sm = '0;
   endtask

   // Drive one EX cycle at the falling edge and push what the next edge must produce.
   task automatic issue(input logic v, input logic fl, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic [12:0] imm, input logic pred);
      res_t e;
      logic r, lg, c;
      logic [31:0] t;
      @(negedge clk);
      ifc.ex_valid = v; ifc.ex_flush = fl; ifc.ex_opcode = op; ifc.ex_funct3 = f3;
      ifc.ex_pc = pc; ifc.ex_rs1 = a; ifc.ex_rs2 = b; ifc.ex_imm = imm; ifc.ex_pred_taken = pred;
      r  = v && !fl && op == 7'b1100011;
      lg = 1'b1; c = 1'b0;
      case (f3)
         3'd0: c = (a == b);
         3'd1: c = (a != b);
         3'd4: c = ($signed(a) < $signed(b));
         3'd5: c = !($signed(a) < $signed(b));
         3'd6: c = (a < b);
         3'd7: c = !(a < b);
         default: lg = 1'b0;
      endcase
      e = '0;
      if (r && lg) begin
         t = pc + {{19{imm[12]}}, imm};
         e.valid = 1'b1; e.taken = c; e.mis = c ^ pred;
         m_tgt = t; m_red = c ? t : pc + 32'd4;
         if (c && mbht[pc[7:2]] != 2'b11) mbht[pc[7:2]] = mbht[pc[7:2]] + 2'b01;
         if (!c && mbht[pc[7:2]] != 2'b00) mbht[pc[7:2]] = mbht[pc[7:2]] - 2'b01;
         if (m_sb != '1) m_sb = m_sb + 1'b1;
         if ((c ^ pred) && m_sm != '1) m_sm = m_sm + 1'b1;
      end else if (r) begin
         e.ill = 1'b1;
      end
      e.target = m_tgt; e.redirect = m_red; e.sb = m_sb; e.sm = m_sm;
      scb.push_back(e);
   endtask

   task automatic idle();
      issue(1'b0, 1'b0, 7'h00, 3'd0, 32'h0, 32'h0, 32'h0, 13'h0, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ifc.if_pc = 32'h100; ifc.ex_valid = 1'b0; ifc.ex_flush = 1'b0; ifc.ex_opcode = '0;
      ifc.ex_funct3 = '0; ifc.ex_pc = '0; ifc.ex_rs1 = '0; ifc.ex_rs2 = '0; ifc.ex_imm = '0;
      ifc.ex_pred_taken = 1'b0;
      model_reset();
      #3;
      checks++;
      if ({ifc.br_valid, ifc.br_taken, ifc.br_mispredict, ifc.br_illegal, ifc.br_target,
           ifc.redirect_pc, ifc.stat_branches, ifc.stat_mispredicts} !== '0) begin
         errors++; $display("FAIL reset_outputs got v=%0b tgt=%h sb=%0d want all zero",
                            ifc.br_valid, ifc.br_target, ifc.stat_branches);
      end
      checks++;
      if (ifc.if_pred_taken !== 1'b0) begin
         errors++; $display("FAIL reset_pred got %0b want 0", ifc.if_pred_taken);
      end
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_beq_basic();
      issue(1, 0, 7'h63, 3'd0, 32'h100, 32'd5, 32'd5, 13'd16, 1'b0);
      idle();
      ifc.if_pc = 32'h100; #1;
      checks++;
      if (ifc.if_pred_taken !== 1'b1) begin
         errors++; $display("FAIL beq_pred got %0b want 1", ifc.if_pred_taken);
      end
   endtask

   task automatic test_signed_unsigned();
      issue(1, 0, 7'h63, 3'd4, 32'h10, 32'hFFFFFFFF, 32'd1, 13'd32, 1'b0); // BLT taken
      issue(1, 0, 7'h63, 3'd6, 32'h14, 32'hFFFFFFFF, 32'd1, 13'd32, 1'b1); // BLTU not taken
      issue(1, 0, 7'h63, 3'd5, 32'h18, 32'hFFFFFFFF, 32'd1, 13'd32, 1'b1); // BGE not taken
      issue(1, 0, 7'h63, 3'd7, 32'h1C, 32'hFFFFFFFF, 32'd1, 13'd32, 1'b1); // BGEU taken
      idle();
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 4; i++)
         issue(1, 0, 7'h63, 3'd1, 32'h204, 32'd1, 32'd2, 13'h1F00, 1'b1);
      idle();
      ifc.if_pc = 32'h204; #1;
      checks++;
      if (ifc.if_pred_taken !== 1'b1 || mbht[1] !== 2'b11) begin
         errors++; $display("FAIL sat_taken got %0b want 1", ifc.if_pred_taken);
      end
      issue(1, 0, 7'h63, 3'd1, 32'h204, 32'd7, 32'd7, 13'h1F00, 1'b1);
      idle(); #1;
      checks++;
      if (ifc.if_pred_taken !== 1'b1) begin
         errors++; $display("FAIL sat_one_nt got %0b want 1", ifc.if_pred_taken);
      end
      issue(1, 0, 7'h63, 3'd1, 32'h204, 32'd7, 32'd7, 13'h1F00, 1'b1);
      idle(); #1;
      checks++;
      if (ifc.if_pred_taken !== 1'b0) begin
         errors++; $display("FAIL sat_two_nt got %0b want 0", ifc.if_pred_taken);
      end
   endtask

   task automatic test_wrap();
      issue(1, 0, 7'h63, 3'd0, 32'h0, 32'd3, 32'd3, 13'h1FFC, 1'b1);        // target 0xFFFFFFFC
      issue(1, 0, 7'h63, 3'd1, 32'hFFFFFFFC, 32'd9, 32'd9, 13'd8, 1'b0);    // redirect 0x0
      idle();
   endtask

   task automatic test_no_bypass();
      logic pre;
      ifc.if_pc = 32'h20C;
      pre = mbht[3][1];
      issue(1, 0, 7'h63, 3'd0, 32'h20C, 32'd4, 32'd4, 13'd4, 1'b0);
      #1;
      checks++;
      if (ifc.if_pred_taken !== pre) begin
         errors++; $display("FAIL no_bypass got %0b want %0b", ifc.if_pred_taken, pre);
      end
      idle(); #1;
      checks++;
      if (ifc.if_pred_taken !== 1'b1) begin
         errors++; $display("FAIL post_update got %0b want 1", ifc.if_pred_taken);
      end
   endtask

   task automatic test_illegal_flush();
      ifc.if_pc = 32'h208;
      issue(1, 0, 7'h63, 3'd2, 32'h208, 32'd1, 32'd1, 13'd64, 1'b0); // illegal funct3
      issue(1, 0, 7'h63, 3'd3, 32'h208, 32'd1, 32'd2, 13'd64, 1'b0); // illegal funct3
      issue(1, 1, 7'h63, 3'd0, 32'h208, 32'd1, 32'd1, 13'd64, 1'b0); // flushed
      issue(1, 0, 7'h33, 3'd0, 32'h208, 32'd1, 32'd1, 13'd64, 1'b0); // not a branch
      issue(0, 0, 7'h63, 3'd0, 32'h208, 32'd1, 32'd1, 13'd64, 1'b0); // invalid
      idle(); #1;
      checks++;
      if (ifc.if_pred_taken !== 1'b0) begin
         errors++; $display("FAIL illegal_counter got %0b want 0", ifc.if_pred_taken);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 20; i++)
         issue(1, 0, 7'h63, 3'd0, 32'h308, 32'(i), 32'(i), 13'd12, 1'b0);
      idle(); #1;
      checks++;
      if (ifc.stat_branches !== 4'hF || ifc.stat_mispredicts !== 4'hF) begin
         errors++; $display("FAIL stat_sat got b=%0d m=%0d want 15 15",
                            ifc.stat_branches, ifc.stat_mispredicts);
      end
   endtask

   task automatic test_reset_mid();
      ifc.if_pc = 32'h308;
      issue(1, 0, 7'h63, 3'd0, 32'h308, 32'd1, 32'd1, 13'd12, 1'b0);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      checks++;
      if (ifc.stat_branches !== '0 || ifc.stat_mispredicts !== '0 || ifc.br_valid !== 1'b0 ||
          ifc.br_target !== '0) begin
         errors++; $display("FAIL mid_reset got b=%0d m=%0d v=%0b tgt=%h want 0 0 0 0",
                            ifc.stat_branches, ifc.stat_mispredicts, ifc.br_valid, ifc.br_target);
      end
      checks++;
      if (ifc.if_pred_taken !== 1'b0) begin
         errors++; $display("FAIL mid_reset_pred got %0b want 0", ifc.if_pred_taken);
      end
      model_reset();
      @(negedge clk);
      reset = 1'b0; ifc.ex_valid = 1'b0;
      issue(1, 0, 7'h63, 3'd1, 32'h308, 32'd1, 32'd2, 13'd12, 1'b1);
      idle(); idle();
   endtask

   initial begin
      test_reset();
      test_beq_basic();
      test_signed_unsigned();
      test_saturate();
      test_wrap();
      test_no_bypass();
      test_illegal_flush();
      test_back_to_back();
      test_reset_mid();
      repeat (3) @(negedge clk);
      checks++;
      if (scb.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain got %0d pending want 0", scb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
